mem_access_stage: RTL
=====================

# mem_access_stage

Load/store access stage of the RV32 pipeline, between execute and writeback. Takes one operation per handshake from execute and drives a req/gnt/rvalid data-memory port. Store data is byte-lane aligned and byte enables are generated. Load data is extracted, sign- or zero-extended, and presented to writeback as a registered one-cycle `wb_en`/`wb_reg`/`wb_val` result. Non-memory ALU results pass through with one cycle of latency so that writeback sees a single uniform source.

## Interface
- `ADDR_W`, default 32: data address width.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `ex_valid` in 1: execute presents an operation.
- `ex_ready` out 1: stage can accept. High only in IDLE.
- `ex_load` in 1: operation is a load.
- `ex_store` in 1: operation is a store. `ex_load` and `ex_store` are never both high.
- `ex_f3` in 3: funct3 field. Selects access width and signedness.
- `ex_addr` in ADDR_W: effective address.
- `ex_wdata` in 32: rs2 store data.
- `ex_rd` in 5: destination register.
- `ex_reg_w_en` in 1: register write enable for non-memory operations.
- `ex_alu_out` in 32: ALU result for non-memory operations.
- `dm_req` out 1: memory request.
- `dm_we` out 1: 1 for a store, 0 for a load.
- `dm_addr` out ADDR_W: word-aligned address (bits [1:0] = 0).
- `dm_be` out 4: byte enables.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_gnt` in 1: request accepted.
- `dm_rvalid` in 1: load data valid.
- `dm_rdata` in 32: load data word.
- `wb_en` out 1: write-back strobe, one-cycle pulse.
- `wb_reg` out 5: write-back register.
- `wb_val` out 32: write-back value.
- `misalign` out 1: misaligned-access pulse. Held at 0 unless the feature in Configuration is compiled in.

## Operation
- The FSM has three states: IDLE, REQ, WAIT.
- An operation is accepted on `ex_valid && ex_ready`. Address, f3, data and rd are captured on acceptance.
- **IDLE, non-memory operation:** on the next cycle `wb_en = ex_reg_w_en && (ex_rd != 0)`, `wb_reg = ex_rd` and `wb_val = ex_alu_out`. The FSM stays in IDLE.
- **IDLE, load or store with legal f3:** go to REQ.
  - Legal load f3 values: 000, 001, 010, 100, 101.
  - Legal store f3 values: 000, 001, 010.
- **IDLE, load or store with illegal f3:** retired with no bus request. `wb_en = 0` on the next cycle.
- **REQ:**
  - `dm_req = 1`. `dm_addr`, `dm_we`, `dm_be` and `dm_wdata` are held stable until `dm_gnt`.
  - On `dm_gnt` for a store: go to IDLE. `wb_en` stays 0.
  - On `dm_gnt` for a load: go to WAIT.
  - `dm_rvalid` is ignored in REQ.
- **WAIT:**
  - `dm_req = 0`.
  - On `dm_rvalid`, select the lane using `addr[1:0]`.
  - lb/lbu: byte `addr[1:0]`, sign- or zero-extended from bit 7.
  - lh/lhu: half selected by `addr[1]`, extended from bit 15.
  - lw: full word.
  - Next cycle: `wb_en = (rd != 0)`, `wb_reg = rd`, `wb_val` = extended value. Go to IDLE.
- **Store lanes:**
  - sb: `dm_be = 4'b0001 << addr[1:0]`, `dm_wdata = {4{wdata[7:0]}}`.
  - sh: `dm_be = addr[1] ? 4'b1100 : 4'b0011`, `dm_wdata = {2{wdata[15:0]}}`.
  - sw: `dm_be = 4'b1111`, `dm_wdata = wdata`.
- For loads, `dm_be` is the same lane mask as the corresponding store width.
- `wb_en` is never asserted for rd = x0.

## Timing
- **Reset** (`rst_n` low, asynchronous): state goes to IDLE and every output goes to 0, except `ex_ready`, which is 1 once the FSM is in IDLE.
- **Reset mid-operation:** any REQ/WAIT operation is abandoned. A `dm_rvalid` arriving afterwards is ignored because IDLE ignores `rvalid`.
- **Pass-through latency:** 1 cycle from acceptance to `wb_en`.
- **Store latency:** acceptance at cycle 0, `dm_req` from cycle 1, retire on the `dm_gnt` cycle.
- **Load latency:**
  - Acceptance at cycle 0, `dm_req` at cycle 1.
  - Earliest `dm_gnt` is cycle 1 and earliest `dm_rvalid` is cycle 2, giving `wb_en` at cycle 3 (minimum 3 cycles).
  - Every gnt or rvalid stall cycle adds 1.
- **Back-pressure:** `ex_ready = 0` in REQ and WAIT. The next operation can be accepted in the cycle after retirement.
- **Result outputs:** `wb_*` are registered. `wb_en` is high for exactly one cycle per result; `wb_reg`/`wb_val` hold their last value otherwise.

## Configuration
- Macro: `MEM_ACCESS_MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned access (lh/lhu/sh with `addr[0]=1`, or lw/sw with `addr[1:0]!=0`) issues no request.
  - `misalign` pulses 1 on the cycle after acceptance, with `wb_en = 0`. The FSM stays in IDLE.
- Undefined:
  - `misalign` is tied 0.
  - Address low bits are forced aligned: half accesses clear bit 0, word accesses clear bits [1:0]. Lane selection then follows the forced address.

## Test plan
- lb, `addr=0x1003`, `dm_rdata=0x80FF_0000` -> `dm_be=4'b1000`, `wb_val=0xFFFF_FF80`, `wb_en` pulses at cycle 3 with gnt at 1 and rvalid at 2.
- lhu, `addr=0x2002`, `rd=5`, `dm_rdata=0xBEEF_1234` -> `wb_val=0x0000_BEEF`, `wb_reg=5`. The same load with `rd=0` -> `wb_en` stays 0.
- sb, `addr=0x13`, `wdata=0x0000_00A5`, `dm_gnt` delayed 3 cycles -> `dm_req` held 4 cycles, `dm_addr=0x10`, `dm_be=4'b1000`, `dm_wdata=0xA5A5_A5A5`, `ex_ready=0` throughout, `wb_en` never asserted.
- ALU op, `rd=7`, `alu_out=0x1234` -> `wb_en=1`, `wb_reg=7`, `wb_val=0x1234` one cycle later. A back-to-back second op is accepted the next cycle.
- lw at `0x1002`:
  - With the macro: `misalign=1` for 1 cycle, `dm_req` stays 0.
  - Without the macro: `dm_addr=0x1000`, `dm_be=4'b1111`.
- Load in WAIT, `rst_n` pulsed low, then `dm_rvalid` -> all outputs 0 and `wb_en` never asserted. The next load completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// RV32 load/store access stage: execute handshake in, req/gnt/rvalid data port out, registered writeback.
// Optional misaligned-access trap compiled in with `define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_f3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_w_en,
    input  logic [31:0]       ex_alu_out,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [31:0]       dm_rdata,
    output logic              wb_en,
    output logic [4:0]        wb_reg,
    output logic [31:0]       wb_val,
    output logic              misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              we_q, we_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_reg_q, wb_reg_d;
    logic [31:0]       wb_val_q, wb_val_d;
    logic [ADDR_W-1:0] acc_addr;
    logic              is_mem;
    logic              go_req;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
        end
        return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lane_mask = 4'b0001 << lo;
            2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   store_lanes = {4{wd[7:0]}};
            2'b01:   store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        // f3[2] marks the unsigned variants (lbu/lhu)
        case (f3[1:0])
            2'b00:   load_extract = {{24{~f3[2] & b[7]}}, b};
            2'b01:   load_extract = {{16{~f3[2] & h[15]}}, h};
            default: load_extract = rdata;
        endcase
    endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == 2'b01) && lo[0]) || ((size == 2'b10) && (lo != 2'b00));
    endfunction
`else
    function automatic logic [ADDR_W-1:0] force_align(input logic [1:0] size,
                                                      input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        if (size == 2'b01) begin
            r[0] = 1'b0;
        end else if (size == 2'b10) begin
            r[1:0] = 2'b00;
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        f3_d     = f3_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        we_d     = we_q;
        wb_en_d  = 1'b0;
        wb_reg_d = wb_reg_q;
        wb_val_d = wb_val_q;
        is_mem   = ex_load | ex_store;
        go_req   = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
        acc_addr   = ex_addr;
`else
        acc_addr   = force_align(ex_f3[1:0], ex_addr);
`endif

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_en_d  = ex_reg_w_en && (ex_rd != 5'd0);
                        wb_reg_d = ex_rd;
                        wb_val_d = ex_alu_out;
                    end else if (f3_legal(ex_load, ex_f3)) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        if (is_misaligned(ex_f3[1:0], ex_addr[1:0])) begin
                            misalign_d = 1'b1;
                        end else begin
                            go_req = 1'b1;
                        end
`else
                        go_req = 1'b1;
`endif
                    end
                end
                if (go_req) begin
                    addr_d  = acc_addr;
                    f3_d    = ex_f3;
                    wdata_d = ex_wdata;
                    rd_d    = ex_rd;
                    we_d    = ex_store;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dm_gnt) begin
                    state_d = we_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    wb_en_d  = (rd_q != 5'd0);
                    wb_reg_d = rd_q;
                    wb_val_d = load_extract(f3_q, addr_q[1:0], dm_rdata);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            f3_q     <= 3'b000;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            we_q     <= 1'b0;
            wb_en_q  <= 1'b0;
            wb_reg_q <= 5'd0;
            wb_val_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            wb_en_q  <= wb_en_d;
            wb_reg_q <= wb_reg_d;
            wb_val_q <= wb_val_d;
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Bus outputs are only driven while a request is outstanding; zero otherwise
    assign ex_ready = (state_q == IDLE);
    assign dm_req   = (state_q == REQ);
    assign dm_we    = dm_req & we_q;
    assign dm_addr  = dm_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dm_be    = dm_req ? lane_mask(f3_q[1:0], addr_q[1:0]) : 4'b0000;
    assign dm_wdata = (dm_req && we_q) ? store_lanes(f3_q[1:0], wdata_q) : 32'd0;
    assign wb_en    = wb_en_q;
    assign wb_reg   = wb_reg_q;
    assign wb_val   = wb_val_q;

endmodule
